ram_march_bist: RTL and testbench

- Built-in self-test controller that sits directly upstream of the 8-bit block RAM.
- Owns the RAM's address, data, w_r and cs inputs during a test and consumes the RAM's out bus.
- On a start pulse it runs a four-element march test over every location and checks each read-back against the expected value.
- Reports pass/fail, the first failing location, and a saturating error count to the system controller.

---
 rtl/ram_bist_pkg.sv | 24 ++
 rtl/ram_bist_addr_gen.sv | 45 ++++
 rtl/ram_march_bist.sv | 195 +++++++++++++++++++
 tb/tb_ram_march_bist.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and march-element tables for the RAM march BIST controller.
// Element tables are indexed by the element code (bit n describes element Mn).
package ram_bist_pkg;

    typedef enum logic [2:0] {IDLE, M0_WR, RD, CMP_WR, DONE} state_t;

    typedef enum logic [1:0] {M0, M1, M2, M3} elem_t;

    // 1 = element walks addresses from DEPTH-1 down to 0
    localparam logic [3:0] ELEM_DESC   = 4'b0100;
    // 1 = element expects the complemented background on read
    localparam logic [3:0] ELEM_RD_INV = 4'b0100;
    // 1 = element writes (M0 in its own state, M1/M2 in the compare cycle)
    localparam logic [3:0] ELEM_WR     = 4'b0111;
    // 1 = element writes the complemented background
    localparam logic [3:0] ELEM_WR_INV = 4'b0010;

    localparam logic [7:0] ERR_MAX = 8'd255;

    function automatic elem_t next_elem(input elem_t e);
        return elem_t'(e + 2'd1);
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter for the march BIST; stops at its terminal value.
// The direction is latched on load so the terminal flag never depends on this cycle's controls.
module ram_bist_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              desc,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;

    always_comb begin
        addr_d = addr_q;
        dir_d  = dir_q;
        if (load) begin
            dir_d  = desc;
            addr_d = desc ? TOP_ADDR : '0;
        end else if (step && !last) begin
            addr_d = dir_q ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            dir_q  <= dir_d;
        end
    end

    assign last = dir_q ? (addr_q == '0) : (addr_q == TOP_ADDR);
    assign addr = addr_q;

endmodule

// File: rtl/ram_march_bist.sv
// March BIST controller: M0 w(P) up, M1 r(P)w(~P) up, M2 r(~P)w(P) down, M3 r(P) up.
// Reports pass/fail, the first failing location and a saturating mismatch count.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter int         DATA_W  = 8,
    parameter int         DEPTH   = 256,
    parameter int         RD_LAT  = 1,
    parameter logic [7:0] PATTERN = 8'h55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_w_r,
    output logic              ram_cs,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    localparam logic [DATA_W-1:0] PAT      = DATA_W'(PATTERN);
    localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);

    state_t            state_q, state_d;
    elem_t             elem_q, elem_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              cs_q, cs_d, w_r_q, w_r_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
    logic [DATA_W-1:0] exp_val;
    logic              ag_load, ag_desc, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;

    ram_bist_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (ag_load),
        .desc (ag_desc),
        .step (ag_step),
        .addr (ag_addr),
        .last (ag_last)
    );

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        cs_d        = cs_q;
        w_r_d       = w_r_q;
        data_d      = data_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        ag_load     = 1'b0;
        ag_desc     = 1'b0;
        ag_step     = 1'b0;
        exp_val     = ELEM_RD_INV[elem_q] ? ~PAT : PAT;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = M0_WR;
                    elem_d      = M0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    ag_load     = 1'b1;
                    ag_desc     = ELEM_DESC[M0];
                    cs_d        = 1'b1;
                    w_r_d       = 1'b1;
                    data_d      = PAT;
                end
            end
            M0_WR: begin
                if (!ag_last) begin
                    ag_step = 1'b1;
                end else begin
                    state_d = RD;
                    elem_d  = M1;
                    ag_load = 1'b1;
                    ag_desc = ELEM_DESC[M1];
                    lat_d   = '0;
                    w_r_d   = 1'b0;
                end
            end
            RD: begin
                if (lat_q == LAT_LAST) begin
                    state_d = CMP_WR;
                    cs_d    = ELEM_WR[elem_q];
                    w_r_d   = ELEM_WR[elem_q];
                    data_d  = ELEM_WR_INV[elem_q] ? ~PAT : PAT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            CMP_WR: begin
                // Capture the first failure before the counter moves off zero
                if (ram_out != exp_val) begin
                    if (err_q == '0) begin
                        fail_addr_d = ag_addr;
                        fail_exp_d  = exp_val;
                        fail_got_d  = ram_out;
                    end
                    if (err_q != ERR_MAX) err_d = err_q + 8'd1;
                end
                if (ag_last && elem_q == M3) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    cs_d    = 1'b0;
                    w_r_d   = 1'b0;
                end else begin
                    state_d = RD;
                    lat_d   = '0;
                    cs_d    = 1'b1;
                    w_r_d   = 1'b0;
                    if (ag_last) begin
                        elem_d  = next_elem(elem_q);
                        ag_load = 1'b1;
                        ag_desc = ELEM_DESC[elem_d];
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_q      <= M0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cs_q        <= 1'b0;
            w_r_q       <= 1'b0;
            data_q      <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            cs_q        <= cs_d;
            w_r_q       <= w_r_d;
            data_q      <= data_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
        end
    end

    assign ram_address = ag_addr;
    assign ram_data    = data_q;
    assign ram_w_r     = w_r_q;
    assign ram_cs      = cs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_addr   = fail_addr_q;
    assign fail_exp    = fail_exp_q;
    assign fail_got    = fail_got_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist: three instances (DEPTH/RD_LAT = 16/1, 16/2, 256/1),
// each with a behavioural RAM that can inject stuck-at or all-zero read faults.
module tb_ram_march_bist;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0]      rst;
   logic [NI-1:0]      start;
   wire  [NI-1:0]      cs, w_r, busy, done, pass;
   wire  [NI-1:0][7:0] addr, wdata, rdata, errc, faddr, fexp, fgot;

   // 0 = healthy, 1 = stuck-at-0, 2 = stuck-at-1, 3 = every read returns 0
   int fmode [NI];
   int fa    [NI];
   int fb    [NI];

   int checks = 0;
   int errors = 0;

   function automatic int depthOf(input int g);
      return (g == 2) ? 256 : 16;
   endfunction

   function automatic int latOf(input int g);
      return (g == 1) ? 2 : 1;
   endfunction

   function automatic logic [7:0] applyFault(input int mode, input int fAddr, input int fBit,
                                             input int a, input logic [7:0] v);
      logic [7:0] m;
      m = 8'(1 << fBit);
      if (mode == 3) return 8'h00;
      if (a != fAddr) return v;
      if (mode == 1) return v & ~m;
      if (mode == 2) return v | m;
      return v;
   endfunction

   // Plays the march algorithm on an abstract memory and records what a correct BIST reports
   task automatic marchModel(input int g, output int errs, output int fAddrOut,
                             output int fExpOut, output int fGotOut);
      int         mem [256];
      int         d;
      int         a;
      logic [7:0] expV, gotV;
      d = depthOf(g);
      errs = 0; fAddrOut = 0; fExpOut = 0; fGotOut = 0;
      for (int i = 0; i < d; i++) mem[i] = 8'h55;
      for (int e = 1; e <= 3; e++) begin
         for (int k = 0; k < d; k++) begin
            a    = (e == 2) ? d - 1 - k : k;
            expV = (e == 2) ? 8'hAA : 8'h55;
            gotV = applyFault(fmode[g], fa[g], fb[g], a, 8'(mem[a]));
            if (gotV != expV) begin
               if (errs == 0) begin
                  fAddrOut = a; fExpOut = int'(expV); fGotOut = int'(gotV);
               end
               if (errs < 255) errs++;
            end
            if (e == 1) mem[a] = 8'hAA;
            if (e == 2) mem[a] = 8'h55;
         end
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int D = (g == 2) ? 256 : 16;
      localparam int L = (g == 1) ? 2 : 1;
      logic [7:0] mem [256];
      logic [7:0] pipe0, pipe1;

      ram_march_bist #(
         .ADDR_W(8), .DATA_W(8), .DEPTH(D), .RD_LAT(L), .PATTERN(8'h55)
      ) dut (
         .clk(clk), .rst(rst[g]), .start(start[g]),
         .ram_address(addr[g]), .ram_data(wdata[g]), .ram_w_r(w_r[g]), .ram_cs(cs[g]),
         .ram_out(rdata[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
         .err_count(errc[g]), .fail_addr(faddr[g]), .fail_exp(fexp[g]), .fail_got(fgot[g])
      );

      // Behavioural RAM: registered read, extra output stage when the latency is two
      always @(posedge clk) begin
         if (cs[g] && w_r[g]) mem[addr[g]] <= wdata[g];
         if (cs[g] && !w_r[g])
            pipe0 <= applyFault(fmode[g], fa[g], fb[g], int'(addr[g]), mem[addr[g]]);
         pipe1 <= pipe0;
      end
      assign rdata[g] = (L == 1) ? pipe0 : pipe1;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Starts a test, optionally holding start or re-pulsing it mid-run, and waits for done
   task automatic applyStimulus(input int g, input int hold, input int pulseAt,
                                output int n, output int rdCyc, output int wrCyc);
      @(negedge clk);
      start[g] = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("busy_after_start_i%0d", g), int'(busy[g]), 1);
      checkOutput($sformatf("done_cleared_i%0d", g), int'(done[g]), 0);
      n = 0; rdCyc = 0; wrCyc = 0;
      if (cs[g] && !w_r[g]) rdCyc++;
      if (cs[g] && w_r[g]) wrCyc++;
      while (!done[g] && n < 4000) begin
         if (n >= hold - 1) start[g] = 1'b0;
         if (n == pulseAt) start[g] = 1'b1;
         @(posedge clk); #1;
         n++;
         if (!done[g]) begin
            if (cs[g] && !w_r[g]) rdCyc++;
            if (cs[g] && w_r[g]) wrCyc++;
         end
      end
      start[g] = 1'b0;
      checkOutput($sformatf("done_reached_i%0d", g), int'(done[g]), 1);
   endtask

   task automatic checkResult(input int g, input string name, input int n);
      int errs, mA, mE, mG, d;
      d = depthOf(g);
      marchModel(g, errs, mA, mE, mG);
      checkOutput({name, "_cycles"}, n, d + 3 * d * (latOf(g) + 1));
      checkOutput({name, "_pass"}, int'(pass[g]), (errs == 0) ? 1 : 0);
      checkOutput({name, "_err_count"}, int'(errc[g]), errs);
      checkOutput({name, "_fail_addr"}, int'(faddr[g]), mA);
      checkOutput({name, "_fail_exp"}, int'(fexp[g]), mE);
      checkOutput({name, "_fail_got"}, int'(fgot[g]), mG);
      checkOutput({name, "_busy_low"}, int'(busy[g]), 0);
      checkOutput({name, "_cs_low"}, int'(cs[g]), 0);
   endtask

   initial begin
      int n, rdCyc, wrCyc;
      rst = '1;
      start = '0;
      for (int i = 0; i < NI; i++) begin
         fmode[i] = 0; fa[i] = 0; fb[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("reset_cs_i%0d", i), int'(cs[i]), 0);
         checkOutput($sformatf("reset_busy_i%0d", i), int'(busy[i]), 0);
         checkOutput($sformatf("reset_done_i%0d", i), int'(done[i]), 0);
         checkOutput($sformatf("reset_pass_i%0d", i), int'(pass[i]), 0);
         checkOutput($sformatf("reset_errc_i%0d", i), int'(errc[i]), 0);
         checkOutput($sformatf("reset_fail_addr_i%0d", i), int'(faddr[i]), 0);
      end
      rst = '0;

      // Healthy RAM, DEPTH 16, latency 1
      applyStimulus(0, 1, -5, n, rdCyc, wrCyc);
      checkResult(0, "clean_i0", n);
      for (int a = 0; a < 16; a++)
         checkOutput($sformatf("mem_final_%0d", a), int'(g_inst[0].mem[a]), 8'h55);

      // Address 5 bit 0 stuck at 1: only the M2 read of ~P can see it
      fmode[0] = 2; fa[0] = 5; fb[0] = 0;
      applyStimulus(0, 1, -5, n, rdCyc, wrCyc);
      checkResult(0, "sa1_a5", n);
      checkOutput("sa1_a5_exp_direct", int'(fexp[0]), 8'hAA);
      checkOutput("sa1_a5_got_direct", int'(fgot[0]), 8'hAB);

      // Random stuck-at faults on both DEPTH-16 instances
      for (int r = 0; r < 4; r++) begin
         for (int g = 0; g < 2; g++) begin
            fmode[g] = int'($urandom_range(0, 2));
            fa[g]    = int'($urandom_range(0, 15));
            fb[g]    = int'($urandom_range(0, 7));
            applyStimulus(g, 1, -5, n, rdCyc, wrCyc);
            checkResult(g, $sformatf("rand%0d_i%0d", r, g), n);
         end
      end

      // Latency 2: every read holds cs=1/w_r=0 for two cycles
      fmode[1] = 0;
      applyStimulus(1, 1, -5, n, rdCyc, wrCyc);
      checkResult(1, "lat2_clean", n);
      checkOutput("lat2_read_cycles", rdCyc, 3 * 16 * 2);
      checkOutput("lat2_write_cycles", wrCyc, 3 * 16);

      // All-zero reads on 256 locations: 768 mismatches saturate the counter
      fmode[2] = 3;
      applyStimulus(2, 1, -5, n, rdCyc, wrCyc);
      checkResult(2, "zero_d256", n);
      fmode[2] = 2; fa[2] = int'($urandom_range(0, 255)); fb[2] = int'($urandom_range(0, 7));
      applyStimulus(2, 1, -5, n, rdCyc, wrCyc);
      checkResult(2, "rand_d256", n);

      // Reset during M2 after the stuck bit at address 5 has been counted
      fmode[0] = 2; fa[0] = 5; fb[0] = 0;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (75) @(posedge clk);
      #1;
      checkOutput("pre_rst_errc", int'(errc[0]), 1);
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      checkOutput("mid_rst_cs", int'(cs[0]), 0);
      checkOutput("mid_rst_busy", int'(busy[0]), 0);
      checkOutput("mid_rst_done", int'(done[0]), 0);
      checkOutput("mid_rst_errc", int'(errc[0]), 0);
      checkOutput("mid_rst_fail_addr", int'(faddr[0]), 0);
      fmode[0] = 0;
      applyStimulus(0, 1, -5, n, rdCyc, wrCyc);
      checkResult(0, "after_rst", n);

      // start held three cycles and re-pulsed during M1: still exactly one test
      applyStimulus(0, 3, 30, n, rdCyc, wrCyc);
      checkResult(0, "start_ignored", n);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_after_done_busy", int'(busy[0]), 0);
      checkOutput("idle_after_done_done", int'(done[0]), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
